// File: rtl/traffic_pkg.sv
// traffic_pkg: shared width default, 7-segment constants, digit indices and decoder
// Segment encoding is {g,f,e,d,c,b,a}, active-high.
package traffic_pkg;
  localparam int TIME_W_DEF = 7;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [1:0] DIG_NS_ONES = 2'd0;
  localparam logic [1:0] DIG_NS_TENS = 2'd1;
  localparam logic [1:0] DIG_EW_ONES = 2'd2;
  localparam logic [1:0] DIG_EW_TENS = 2'd3;

  function automatic logic [6:0] seg7_decode(input logic [3:0] n);
    case (n)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/traffic_countdown_display_if.sv
// traffic_countdown_display_if: display bus between traffic controller and display
// master drives ce/timeLeftNS/timeLeftEW and reads seg/an; slave is the display.
interface traffic_countdown_display_if import traffic_pkg::*; #(
  parameter int TIME_W = TIME_W_DEF
);
  logic ce;
  logic [TIME_W-1:0] timeLeftNS;
  logic [TIME_W-1:0] timeLeftEW;
  logic [6:0] seg;
  logic [3:0] an;
  modport master (output ce, timeLeftNS, timeLeftEW, input seg, an);
  modport slave (input ce, timeLeftNS, timeLeftEW, output seg, an);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: clamp to 99 then 7-iteration shift-add-3 binary to 2-digit BCD
// Ports: clk, rst (async, active-high), start (load bin), bin, busy, done (last
// shift this cycle), bcd (valid once busy drops).
module bin2bcd_seq import traffic_pkg::*; #(
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TIME_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [7:0]        bcd
);
  logic [6:0] val_q;
  logic [7:0] bcd_q, adj;
  logic [2:0] cnt_q;
  assign adj = {(bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4],
                (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0]};
  assign busy = cnt_q != 3'd0;
  assign done = cnt_q == 3'd1;
  assign bcd = bcd_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      val_q <= (bin > TIME_W'(99)) ? 7'd99 : 7'(bin);
      bcd_q <= '0;
      cnt_q <= 3'd7;
    end else if (busy) begin
      bcd_q <= {adj[6:0], val_q[6]};
      val_q <= {val_q[5:0], 1'b0};
      cnt_q <= cnt_q - 3'd1;
    end
  end
endmodule

// File: rtl/traffic_countdown_display.sv
// traffic_countdown_display: 4-digit multiplexed 7-segment countdown display
// Ports: counter (clock), rst (async, active-high), bus (slave: ce, timeLeftNS,
// timeLeftEW in; seg, an out, both registered). an[0..3] = NS ones, NS tens,
// EW ones, EW tens. Define TRAFFIC_DISP_LZB_EN to blank zero tens digits.
module traffic_countdown_display import traffic_pkg::*; #(
  parameter int TIME_W = TIME_W_DEF,
  parameter int SCAN_DIV = 16
) (
  input logic counter,
  input logic rst,
  traffic_countdown_display_if.slave bus
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD_NS = 3'd1;
  localparam logic [2:0] SHIFT_NS = 3'd2;
  localparam logic [2:0] LOAD_EW = 3'd3;
  localparam logic [2:0] SHIFT_EW = 3'd4;
  localparam logic [2:0] COMMIT = 3'd5;
  logic [DW-1:0] div_q;
  logic [1:0] idx_q;
  logic [2:0] state_q, state_d;
  logic [7:0] ns_q, bcd;
  logic [15:0] disp_q;
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, nib;
  logic tc, frame, start, busy, done;
  assign tc = div_q == DW'(SCAN_DIV - 1);
  assign frame = tc && idx_q == DIG_EW_TENS;
  assign start = state_q == LOAD_NS || state_q == LOAD_EW;
  always_comb
    state_d = (state_q == IDLE)     ? (frame ? LOAD_NS : IDLE) :
              (state_q == LOAD_NS)  ? SHIFT_NS :
              (state_q == SHIFT_NS) ? (done ? LOAD_EW : SHIFT_NS) :
              (state_q == LOAD_EW)  ? SHIFT_EW :
              (state_q == SHIFT_EW) ? (done ? COMMIT : SHIFT_EW) : IDLE;
  bin2bcd_seq #(.TIME_W(TIME_W)) u_bcd (
    .clk(counter), .rst(rst), .start(start),
    .bin(state_q == LOAD_NS ? bus.timeLeftNS : bus.timeLeftEW),
    .busy(busy), .done(done), .bcd(bcd)
  );
  assign nib = disp_q[{idx_q, 2'b00} +: 4];
`ifdef TRAFFIC_DISP_LZB_EN
  assign seg_d = ((idx_q == DIG_NS_TENS || idx_q == DIG_EW_TENS) && nib == 4'd0) ? SEG_BLANK : seg7_decode(nib);
`else
  assign seg_d = seg7_decode(nib);
`endif
  // NS result is parked in ns_q while the converter is reused for EW, so both
  // halves of the display always come from the same frame.
  always_ff @(posedge counter or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      state_q <= IDLE;
      ns_q <= '0;
      disp_q <= '0;
      an_q <= '0;
      seg_q <= SEG_BLANK;
    end else begin
      div_q <= tc ? '0 : div_q + DW'(1);
      idx_q <= idx_q + 2'(tc);
      state_q <= state_d;
      if (state_q == LOAD_EW) ns_q <= bcd;
      if (state_q == COMMIT) disp_q <= {bcd, ns_q};
      an_q <= bus.ce ? 4'b0001 << idx_q : 4'b0000;
      seg_q <= bus.ce ? seg_d : SEG_BLANK;
    end
  end
  assign bus.an = an_q;
  assign bus.seg = seg_q;
  a_frame_idle: assert property (@(posedge counter) disable iff (rst) frame |-> (state_q == IDLE && !busy));
endmodule

// File: tb/tb_traffic_countdown_display.sv
// tb_traffic_countdown_display: directed stimulus with a cycle scoreboard of {an,seg}
module tb_traffic_countdown_display;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0, cap_ns = 0, cap_ew = 0, sh_ns = 0, sh_ew = 0;
  int checks = 0, errors = 0;
  logic [10:0] sb [$];
  logic [10:0] exp_s;
`ifdef TRAFFIC_DISP_LZB_EN
  localparam logic [6:0] TZ = 7'h00;
`else
  localparam logic [6:0] TZ = 7'h3F;
`endif

  traffic_countdown_display_if #(.TIME_W(7)) bus ();
  traffic_countdown_display #(.TIME_W(7), .SCAN_DIV(16)) dut (.counter(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic int sat(int v);
    return v > 99 ? 99 : v;
  endfunction

  function automatic logic [6:0] segx(int v, bit tens);
    logic [6:0] t [10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef TRAFFIC_DISP_LZB_EN
    if (tens && v == 0) return 7'h00;
`endif
    return t[v];
  endfunction

  // Expected outputs right after edge c (edges counted from reset release).
  function automatic logic [10:0] expect_out(int c, int sn, int se, logic ce);
    int i;
    i = ((c - 1) / 16) % 4;
    if (!ce) return '0;
    return {4'(1 << i), segx(i == 0 ? sn % 10 : i == 1 ? sn / 10 : i == 2 ? se % 10 : se / 10, i[0])};
  endfunction

  task automatic check(string tag, logic [10:0] obs, logic [10:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed an/seg=%h expected %h", tag, obs, expv);
    end
  endtask

  task automatic at(int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Frame boundary edge is 64k; NS sampled at +1, EW at +9, shown from +18.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0;
      cap_ns <= 0;
      cap_ew <= 0;
      sh_ns <= 0;
      sh_ew <= 0;
      sb.delete();
    end else begin
      cyc <= cyc + 1;
      if (cyc + 1 > 64 && (cyc + 1) % 64 == 1) cap_ns <= sat(int'(bus.timeLeftNS));
      if (cyc + 1 > 64 && (cyc + 1) % 64 == 9) cap_ew <= sat(int'(bus.timeLeftEW));
      if (cyc + 1 > 64 && (cyc + 1) % 64 == 18) begin
        sh_ns <= cap_ns;
        sh_ew <= cap_ew;
        sb.push_back(expect_out(cyc + 1, cap_ns, cap_ew, bus.ce));
      end else begin
        sb.push_back(expect_out(cyc + 1, sh_ns, sh_ew, bus.ce));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && sb.size() > 0) begin
      exp_s = sb.pop_front();
      check("scan", {bus.an, bus.seg}, exp_s);
    end
  end

  initial begin
    bus.ce = 1'b1;
    bus.timeLeftNS = 7'd0;
    bus.timeLeftEW = 7'd0;
    #2 rst = 1'b1;
    #1 check("reset_async", {bus.an, bus.seg}, 11'h000);
    repeat (3) @(negedge clk);
    check("reset_hold", {bus.an, bus.seg}, 11'h000);
    rst = 1'b0;
    at(1);   check("first_edge", {bus.an, bus.seg}, {4'b0001, 7'h3F});
    bus.timeLeftNS = 7'd42;
    bus.timeLeftEW = 7'd7;
    at(16);  check("an0_hold", {bus.an, bus.seg}, {4'b0001, 7'h3F});
    at(17);  check("an1", {bus.an, bus.seg}, {4'b0010, TZ});
    at(33);  check("an2", {bus.an, bus.seg}, {4'b0100, 7'h3F});
    at(49);  check("an3", {bus.an, bus.seg}, {4'b1000, TZ});
    at(65);  check("an_wrap", {bus.an, bus.seg}, {4'b0001, 7'h3F});
    at(97);  check("ew7_ones", {bus.an, bus.seg}, {4'b0100, 7'h07});
    at(113); check("ew7_tens", {bus.an, bus.seg}, {4'b1000, TZ});
    at(129); check("ns42_ones", {bus.an, bus.seg}, {4'b0001, 7'h5B});
    at(145); check("ns42_tens", {bus.an, bus.seg}, {4'b0010, 7'h66});
    bus.timeLeftNS = 7'd127;
    bus.timeLeftEW = 7'd100;
    at(225); check("sat_ew_ones", {bus.an, bus.seg}, {4'b0100, 7'h6F});
    at(241); check("sat_ew_tens", {bus.an, bus.seg}, {4'b1000, 7'h6F});
    at(257); check("sat_ns_ones", {bus.an, bus.seg}, {4'b0001, 7'h6F});
    at(273); check("sat_ns_tens", {bus.an, bus.seg}, {4'b0010, 7'h6F});
    bus.timeLeftNS = 7'd0;
    at(385); check("zero_ones", {bus.an, bus.seg}, {4'b0001, 7'h3F});
    at(401); check("zero_tens", {bus.an, bus.seg}, {4'b0010, TZ});
    bus.timeLeftNS = 7'd3;
    at(452);
    bus.timeLeftNS = 7'd5;
    at(513); check("late_change_held", {bus.an, bus.seg}, {4'b0001, 7'h4F});
    at(577); check("late_change_shown", {bus.an, bus.seg}, {4'b0001, 7'h6D});
    at(580);
    bus.ce = 1'b0;
    at(581); check("blank_start", {bus.an, bus.seg}, 11'h000);
    at(600); check("blank_hold", {bus.an, bus.seg}, 11'h000);
    at(620);
    bus.ce = 1'b1;
    at(621); check("unblank_resume", {bus.an, bus.seg}, {4'b0100, 7'h6F});
    at(650);
    rst = 1'b1;
    #1 check("reset_mid_conv", {bus.an, bus.seg}, 11'h000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    at(1);   check("post_rst_ones", {bus.an, bus.seg}, {4'b0001, 7'h3F});
    at(49);  check("post_rst_ew_tens", {bus.an, bus.seg}, {4'b1000, TZ});
    at(97);  check("post_rst_ew_ones", {bus.an, bus.seg}, {4'b0100, 7'h6F});
    at(129); check("post_rst_ns_ones", {bus.an, bus.seg}, {4'b0001, 7'h6D});
    at(145); check("post_rst_ns_tens", {bus.an, bus.seg}, {4'b0010, TZ});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
